cpu_debug_ctrl: RTL

Parametrised run-control and debug-access unit placed between the external debug host and the CPU core. It halts, resumes and single/multi-steps the core, matches hardware PC breakpoints, and gives the host handshaked word access to core memory and the register file. It replaces the fixed-size, always-ready debug block with a configurable, bus-bridging successor.

---
 rtl/cpu_debug_pkg.sv | 40 ++++
 rtl/cpu_debug_bp_match.sv | 68 ++++++
 rtl/cpu_debug_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_debug_pkg.sv
// Shared types and constants for the CPU run-control / debug-access unit.
// Breakpoint hardware is included only when CPU_DEBUG_BP_EN is defined.
package cpu_debug_pkg;

    typedef enum logic [1:0] {
        RUN_RUNNING  = 2'd0,
        RUN_HALTED   = 2'd1,
        RUN_STEPPING = 2'd2
    } run_state_e;

    typedef enum logic [1:0] {
        ACC_IDLE     = 2'd0,
        ACC_MEM_WAIT = 2'd1,
        ACC_RESP     = 2'd2
    } acc_state_e;

    // What the outstanding host access turned out to be after decode.
    typedef enum logic [1:0] {
        KIND_MEM = 2'd0,
        KIND_REG = 2'd1,
        KIND_CSR = 2'd2,
        KIND_ERR = 2'd3
    } acc_kind_e;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_HALT = 2'd1;
    localparam logic [1:0] CAUSE_STEP = 2'd2;
    localparam logic [1:0] CAUSE_BP   = 2'd3;

    // CSR offsets are small: status, up to 16 breakpoint addresses, enable mask.
    localparam int         CSR_OFF_W  = 5;
    localparam logic [4:0] CSR_STATUS = 5'd0;
    localparam logic [4:0] CSR_BP0    = 5'd1;

    // The enable mask sits right after the last breakpoint address.
    function automatic logic [4:0] csr_bp_en(input int num_bp);
        return 5'(num_bp + 1);
    endfunction

endpackage

// File: rtl/cpu_debug_bp_match.sv
// PC breakpoint comparators: NUM_BP address registers, an enable mask and
// an OR-reduced equality array. Only built when CPU_DEBUG_BP_EN is defined.
module cpu_debug_bp_match
    import cpu_debug_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NUM_BP = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 csr_we,
    input  logic [CSR_OFF_W-1:0] csr_off,
    input  logic [XLEN-1:0]      csr_wdata,
    input  logic [XLEN-1:0]      cpu_pc,
    output logic [XLEN-1:0]      csr_rdata,
    output logic                 bp_hit
);

    localparam logic [CSR_OFF_W-1:0] EN_OFF = csr_bp_en(NUM_BP);

    logic [NUM_BP-1:0] en_q;
    logic [NUM_BP-1:0] hit;
    logic [XLEN-1:0]   addr_vec [NUM_BP];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BP; gi++) begin : gen_bp
            logic [XLEN-1:0] addr_q;

            // Breakpoint address register, written through its CSR offset.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    addr_q <= '0;
                end else if (csr_we && (csr_off == CSR_BP0 + CSR_OFF_W'(gi))) begin
                    addr_q <= csr_wdata;
                end
            end

            assign addr_vec[gi] = addr_q;
            assign hit[gi]      = en_q[gi] & (cpu_pc == addr_q);
        end
    endgenerate

    // Enable mask register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q <= '0;
        end else if (csr_we && (csr_off == EN_OFF)) begin
            en_q <= csr_wdata[NUM_BP-1:0];
        end
    end

    assign bp_hit = |hit;

    // CSR read-back mux; offsets outside this block read 0.
    always_comb begin
        csr_rdata = '0;
        if (csr_off == EN_OFF) begin
            csr_rdata = XLEN'(en_q);
        end
        for (int i = 0; i < NUM_BP; i++) begin
            if (csr_off == CSR_BP0 + CSR_OFF_W'(i)) begin
                csr_rdata = addr_vec[i];
            end
        end
    end

endmodule

// File: rtl/cpu_debug_ctrl.sv
// Run-control (halt/run/step, breakpoints) and handshaked host access to
// memory, register file and debug CSRs. Optional feature macro:
// CPU_DEBUG_BP_EN (hardware PC breakpoints).
module cpu_debug_ctrl
    import cpu_debug_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MEM_WORDS = 1024,
    parameter int NUM_REGS  = 32,
    parameter int NUM_BP    = 4,
    parameter int STEP_W    = 16,
    localparam int RIDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [XLEN-1:0]   dbg_addr,
    input  logic [XLEN-1:0]   dbg_wdata,
    output logic [XLEN-1:0]   dbg_rdata,
    output logic              dbg_ack,
    output logic              dbg_err,
    input  logic              cmd_halt,
    input  logic              cmd_run,
    input  logic              cmd_step,
    input  logic [STEP_W-1:0] step_count,
    input  logic [XLEN-1:0]   cpu_pc,
    input  logic              cpu_retire,
    output logic              cpu_stall,
    output logic              halted,
    output logic [1:0]        halt_cause,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ack,
    output logic              reg_we,
    output logic [RIDX_W-1:0] reg_idx,
    output logic [XLEN-1:0]   reg_wdata,
    input  logic [XLEN-1:0]   reg_rdata
);

    localparam logic [XLEN-1:0] REG_BASE = XLEN'(MEM_WORDS);
    localparam logic [XLEN-1:0] CSR_BASE = XLEN'(MEM_WORDS + NUM_REGS);
    localparam logic [XLEN-1:0] CSR_LAST = CSR_BASE + XLEN'(csr_bp_en(NUM_BP));

    run_state_e            run_q, run_d;
    logic [1:0]            cause_q, cause_d;
    logic [STEP_W-1:0]     cnt_q, cnt_d;
    logic                  first_q, first_d;

    acc_state_e            acc_q, acc_d;
    acc_kind_e             kind_q, kind_d;
    logic                  we_q, we_d;
    logic [XLEN-1:0]       addr_q, addr_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic [XLEN-1:0]       rdata_q, rdata_d;
    logic [RIDX_W-1:0]     ridx_q, ridx_d;
    logic [CSR_OFF_W-1:0]  coff_q, coff_d;

    logic                  resp;
    logic                  raw_hit;
    logic                  bp_hit;
    logic [XLEN-1:0]       bp_rdata;
    logic [XLEN-1:0]       csr_rdata;

    assign resp = (acc_q == ACC_RESP);

`ifdef CPU_DEBUG_BP_EN
    logic csr_we;
    assign csr_we = resp && (kind_q == KIND_CSR) && we_q;

    cpu_debug_bp_match #(
        .XLEN   (XLEN),
        .NUM_BP (NUM_BP)
    ) u_bp (
        .clk       (clk),
        .reset     (reset),
        .csr_we    (csr_we),
        .csr_off   (coff_q),
        .csr_wdata (wdata_q),
        .cpu_pc    (cpu_pc),
        .csr_rdata (bp_rdata),
        .bp_hit    (raw_hit)
    );
`else
    logic unused_pc;
    assign unused_pc = ^cpu_pc;
    assign raw_hit   = 1'b0;
    assign bp_rdata  = '0;
`endif

    // The first instruction of a step may sit on a breakpoint; ignore it there.
    assign bp_hit     = raw_hit & ~((run_q == RUN_STEPPING) & first_q);
    assign halted     = (run_q == RUN_HALTED);
    assign halt_cause = cause_q;
    assign cpu_stall  = halted | bp_hit;

    // Run-control and access state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q   <= RUN_RUNNING;
            cause_q <= CAUSE_NONE;
            cnt_q   <= '0;
            first_q <= 1'b0;
            acc_q   <= ACC_IDLE;
            kind_q  <= KIND_ERR;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ridx_q  <= '0;
            coff_q  <= '0;
        end else begin
            run_q   <= run_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            acc_q   <= acc_d;
            kind_q  <= kind_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ridx_q  <= ridx_d;
            coff_q  <= coff_d;
        end
    end

    // Run FSM: halt beats breakpoint beats retire; step beats run when halted.
    always_comb begin
        run_d   = run_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        case (run_q)
            RUN_RUNNING: begin
                if (cmd_halt) begin
                    run_d   = RUN_HALTED;
                    cause_d = CAUSE_HALT;
                end else if (bp_hit) begin
                    run_d   = RUN_HALTED;
                    cause_d = CAUSE_BP;
                end
            end
            RUN_HALTED: begin
                if (cmd_step) begin
                    run_d   = RUN_STEPPING;
                    cnt_d   = (step_count == '0) ? STEP_W'(1) : step_count;
                    first_d = 1'b1;
                end else if (cmd_run) begin
                    run_d   = RUN_RUNNING;
                    cause_d = CAUSE_NONE;
                end
            end
            RUN_STEPPING: begin
                if (cmd_halt) begin
                    run_d   = RUN_HALTED;
                    cause_d = CAUSE_HALT;
                end else if (bp_hit) begin
                    run_d   = RUN_HALTED;
                    cause_d = CAUSE_BP;
                end else if (cpu_retire) begin
                    first_d = 1'b0;
                    cnt_d   = cnt_q - STEP_W'(1);
                    if (cnt_q == STEP_W'(1)) begin
                        run_d   = RUN_HALTED;
                        cause_d = CAUSE_STEP;
                    end
                end
            end
            default: run_d = RUN_RUNNING;
        endcase
    end

    // Access FSM: decode on request, wait for memory if needed, then ack once.
    always_comb begin
        acc_d   = acc_q;
        kind_d  = kind_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ridx_d  = ridx_q;
        coff_d  = coff_q;
        case (acc_q)
            ACC_IDLE: begin
                if (dbg_req) begin
                    we_d    = dbg_we;
                    addr_d  = dbg_addr;
                    wdata_d = dbg_wdata;
                    ridx_d  = RIDX_W'(dbg_addr - REG_BASE);
                    coff_d  = CSR_OFF_W'(dbg_addr - CSR_BASE);
                    acc_d   = ACC_RESP;
                    if (dbg_addr < REG_BASE) begin
                        kind_d = KIND_MEM;
                        acc_d  = ACC_MEM_WAIT;
                    end else if (dbg_addr < CSR_BASE) begin
                        kind_d = halted ? KIND_REG : KIND_ERR;
                    end else if (dbg_addr <= CSR_LAST) begin
                        kind_d = KIND_CSR;
                    end else begin
                        kind_d = KIND_ERR;
                    end
                end
            end
            ACC_MEM_WAIT: begin
                if (mem_ack) begin
                    rdata_d = mem_rdata;
                    acc_d   = ACC_RESP;
                end
            end
            ACC_RESP: acc_d = ACC_IDLE;
            default:  acc_d = ACC_IDLE;
        endcase
    end

    assign csr_rdata = (coff_q == CSR_STATUS) ? XLEN'({cause_q, halted}) : bp_rdata;

    // Response data is only driven during the ack cycle.
    always_comb begin
        dbg_rdata = '0;
        if (resp) begin
            case (kind_q)
                KIND_MEM: dbg_rdata = rdata_q;
                KIND_REG: dbg_rdata = reg_rdata;
                KIND_CSR: dbg_rdata = csr_rdata;
                default:  dbg_rdata = '0;
            endcase
        end
    end

    assign dbg_ack   = resp;
    assign dbg_err   = resp && (kind_q == KIND_ERR);
    assign mem_req   = (acc_q == ACC_MEM_WAIT);
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign reg_we    = resp && (kind_q == KIND_REG) && we_q;
    assign reg_idx   = ridx_q;
    assign reg_wdata = wdata_q;

endmodule
